// File: rtl/imem_boot_loader_if.sv
// Host byte stream and instruction-memory write port of the boot loader.
// The slave modport is the loader; the master modport is the host/memory side.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_data
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: framed bytes -> 32-bit words into imem (write 1 cycle after 4th byte), then CPU start.
// One byte per cycle; ready depends only on state and drops for good in RUN/ERR.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_start_o,
    output logic                error_o,
    output logic [15:0]         words_o
);
    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic [23:0]       asm_q, asm_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [15:0]       words_q, words_d;

    logic              xfer;
    logic [15:0]       n_hdr;

    assign bus.in_ready = (state_q != S_RUN) && (state_q != S_ERR);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign n_hdr        = {bus.in_data, cnt_q[7:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        words_d    = words_q;
        if (xfer) begin
            // The checksum byte itself is not folded into the running XOR.
            if (state_q != S_CSUM) begin
                xor_d = xor_q ^ bus.in_data;
            end
            unique case (state_q)
                S_HDR0: begin
                    cnt_d   = {8'h00, bus.in_data};
                    state_d = S_HDR1;
                end
                S_HDR1: begin
                    cnt_d = n_hdr;
                    if ({1'b0, n_hdr} > DEPTH_C) begin
                        state_d = S_ERR;
                    end else if (n_hdr == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {bus.in_data, asm_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        data_d  = {bus.in_data, asm_q};
                        words_d = words_q + 16'd1;
                        if (words_q + 16'd1 == cnt_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    state_d = (bus.in_data == xor_q) ? S_RUN : S_ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_HDR0;
            cnt_q      <= 16'd0;
            xor_q      <= 8'd0;
            asm_q      <= 24'd0;
            byte_cnt_q <= 2'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            words_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            words_q    <= words_d;
        end
    end

    assign bus.imem_we   = we_q;
    assign bus.imem_addr = addr_q;
    assign bus.imem_data = data_q;
    assign cpu_start_o   = (state_q == S_RUN);
    assign error_o       = (state_q == S_ERR);
    assign words_o       = words_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes, a monitor checks strobes.
module tb_imem_boot_loader;
    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [15:0] words;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_start_o;
    logic        error_o;
    logic [15:0] words_o;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus.slave),
        .cpu_start_o (cpu_start_o),
        .error_o     (error_o),
        .words_o     (words_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          last_cyc = -1;
    bit          gap_chk = 1'b0;
    wr_t         exp_q[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_i);
            if (bus.imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: addr 0x%0h data 0x%0h, none expected",
                             bus.imem_addr, bus.imem_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                    chk("wr_data", bus.imem_data, e.data);
                    chk("wr_words", 32'(words_o), 32'(e.words));
                end
                if (gap_chk && last_cyc >= 0) chk("strobe_gap", 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mkword(input logic [7:0] i, input logic [7:0] seed);
        return {seed ^ i, i, ~i, seed + i};
    endfunction

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_data", bus.imem_data, 32'd0);
        chk("rst_start", 32'(cpu_start_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_words", 32'(words_o), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hxx;
            repeat (gap) begin
                @(posedge clk_i);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk_i);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready stayed 0 for byte 0x%0h", b);
        end
    endtask

    task automatic build_frame(input int n, input logic [7:0] seed, input bit corrupt);
        logic [31:0] w;
        logic [7:0]  x;
        logic [15:0] nn;
        nn = 16'(n);
        tx_q.delete();
        tx_q.push_back(nn[7:0]);
        tx_q.push_back(nn[15:8]);
        x = nn[7:0] ^ nn[15:8];
        for (int i = 0; i < n; i++) begin
            w = mkword(8'(i), seed);
            for (int k = 0; k < 4; k++) begin
                tx_q.push_back(w[8*k +: 8]);
                x ^= w[8*k +: 8];
            end
            exp_q.push_back('{addr: 8'(i), data: w, words: 16'(i + 1)});
        end
        tx_q.push_back(corrupt ? ~x : x);
    endtask

    task automatic play(input int max_gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == tx_q.size() - 1) chk("start_before_csum", 32'(cpu_start_o), 32'd0);
            send_byte(tx_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic finish_frame(input bit exp_start, input bit exp_err, input int exp_words);
        chk("start_next_cycle", 32'(cpu_start_o), 32'(exp_start));
        chk("error_next_cycle", 32'(error_o), 32'(exp_err));
        // Host keeps pushing junk: the loader must ignore it.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (5) @(posedge clk_i);
        #1;
        bus.in_valid = 1'b0;
        chk("hold_start", 32'(cpu_start_o), 32'(exp_start));
        chk("hold_error", 32'(error_o), 32'(exp_err));
        chk("hold_ready", 32'(bus.in_ready), 32'd0);
        chk("hold_words", 32'(words_o), 32'(exp_words));
        chk("writes_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_i = 1'b1;

        // 1) N=1 hand-computed frame
        do_reset();
        tx_q = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
        exp_q.push_back('{addr: 8'd0, data: 32'h2008_0005, words: 16'd1});
        play(0);
        finish_frame(1'b1, 1'b0, 1);

        // 2) same frame, bad checksum: the word is still written
        do_reset();
        tx_q = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
        exp_q.push_back('{addr: 8'd0, data: 32'h2008_0005, words: 16'd1});
        play(0);
        finish_frame(1'b0, 1'b1, 1);

        // 3a) N=0
        do_reset();
        tx_q = '{8'h00, 8'h00, 8'h00};
        play(0);
        finish_frame(1'b1, 1'b0, 0);

        // 3b) N=257 rejected right after CNT_HI
        do_reset();
        send_byte(8'h01, 0);
        chk("n257_not_yet_err", 32'(error_o), 32'd0);
        send_byte(8'h01, 0);
        finish_frame(1'b0, 1'b1, 0);

        // 4) N=256 back-to-back, strobes exactly 4 cycles apart
        do_reset();
        build_frame(256, 8'h3C, 1'b0);
        last_cyc = -1;
        gap_chk  = 1'b1;
        play(0);
        gap_chk  = 1'b0;
        finish_frame(1'b1, 1'b0, 256);

        // 5) N=3 with random valid gaps
        do_reset();
        build_frame(3, 8'h91, 1'b0);
        play(3);
        finish_frame(1'b1, 1'b0, 3);

        // 6) reset mid-frame, then a clean N=1 frame
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset();
        build_frame(1, 8'hE7, 1'b0);
        play(1);
        finish_frame(1'b1, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
